// File: rtl/minmax_pkg.sv
// Shared types for the streaming min/max scanner.
// Holds the FSM encoding and default sample/index widths.
package minmax_pkg;

    localparam int W_DEF  = 8;
    localparam int CW_DEF = 8;

    typedef logic [W_DEF-1:0]  sample_t;
    typedef logic [CW_DEF-1:0] idx_t;

    typedef enum logic [1:0] {
        ACCEPT,
        CMP_MIN,
        CMP_MAX,
        DONE
    } state_t;

endpackage

// File: rtl/minmax_cmp.sv
// Shared magnitude comparator for the min/max scanner.
// Signed mode flips the sign bits so one unsigned compare serves both.
module minmax_cmp
    import minmax_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_mode,
    output logic         lt,
    output logic         gt
);

    logic [W-1:0] flip;
    logic [W-1:0] a_k;
    logic [W-1:0] b_k;

    assign flip = {signed_mode, {(W-1){1'b0}}};
    assign a_k  = a ^ flip;
    assign b_k  = b ^ flip;
    assign lt   = a_k < b_k;
    assign gt   = a_k > b_k;

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Streaming min/max scanner: one comparator time-shared between the
// running-min and running-max updates, one result per frame.
module minmax_scan_ctrl
    import minmax_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_signed,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_min,
    output logic [W-1:0]  m_max,
    output logic [CW-1:0] m_min_idx,
    output logic [CW-1:0] m_max_idx,
    output logic [CW-1:0] m_count
);

    state_t        state_q, state_d;
    logic          first_q, first_d;
    logic          rdy_q;
    logic          last_q, last_d;
    logic          sgn_q, sgn_d;
    logic [W-1:0]  smp_q, smp_d;
    logic [W-1:0]  min_q, min_d;
    logic [W-1:0]  max_q, max_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] min_idx_q, min_idx_d;
    logic [CW-1:0] max_idx_q, max_idx_d;
    logic [CW-1:0] count_q, count_d;

    logic [W-1:0]  cmp_b;
    logic          cmp_lt;
    logic          cmp_gt;
    logic          s_fire;

    assign cmp_b = (state_q == CMP_MAX) ? max_q : min_q;

    minmax_cmp #(
        .W (W)
    ) u_cmp (
        .a           (smp_q),
        .b           (cmp_b),
        .signed_mode (sgn_q),
        .lt          (cmp_lt),
        .gt          (cmp_gt)
    );

    // rdy_q keeps s_ready low during reset and until the first edge after it
    assign s_ready = rdy_q && (state_q == ACCEPT);
    assign s_fire  = s_valid && s_ready;
    assign m_valid = (state_q == DONE);

    assign m_min     = min_q;
    assign m_max     = max_q;
    assign m_min_idx = min_idx_q;
    assign m_max_idx = max_idx_q;
    assign m_count   = count_q;

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        last_d    = last_q;
        sgn_d     = sgn_q;
        smp_d     = smp_q;
        min_d     = min_q;
        max_d     = max_q;
        idx_d     = idx_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        count_d   = count_q;

        unique case (state_q)
            ACCEPT: begin
                if (s_fire) begin
                    smp_d  = s_data;
                    last_d = s_last;
                    idx_d  = count_q;
                    if (count_q != {CW{1'b1}}) begin
                        count_d = count_q + CW'(1);
                    end
                    if (first_q) begin
                        min_d     = s_data;
                        max_d     = s_data;
                        min_idx_d = '0;
                        max_idx_d = '0;
                        sgn_d     = cfg_signed;
                        first_d   = 1'b0;
                        state_d   = s_last ? DONE : ACCEPT;
                    end else begin
                        state_d = CMP_MIN;
                    end
                end
            end
            CMP_MIN: begin
                if (cmp_lt) begin
                    min_d     = smp_q;
                    min_idx_d = idx_q;
                end
                state_d = CMP_MAX;
            end
            CMP_MAX: begin
                if (cmp_gt) begin
                    max_d     = smp_q;
                    max_idx_d = idx_q;
                end
                state_d = last_q ? DONE : ACCEPT;
            end
            DONE: begin
                if (m_ready) begin
                    first_d = 1'b1;
                    count_d = '0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCEPT;
            first_q   <= 1'b1;
            rdy_q     <= 1'b0;
            last_q    <= 1'b0;
            sgn_q     <= 1'b0;
            smp_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            rdy_q     <= 1'b1;
            last_q    <= last_d;
            sgn_q     <= sgn_d;
            smp_q     <= smp_d;
            min_q     <= min_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Scoreboard bench for minmax_scan_ctrl: directed frames queue their
// expected results, a negedge monitor pops and compares on handshake.
module tb_minmax_scan_ctrl;

    typedef struct packed {
        logic [7:0] mn;
        logic [7:0] mx;
        logic [7:0] mni;
        logic [7:0] mxi;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_signed;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_min;
    logic [7:0] m_max;
    logic [7:0] m_min_idx;
    logic [7:0] m_max_idx;
    logic [7:0] m_count;

    logic       s2_valid;
    logic       s2_ready;
    logic [7:0] s2_data;
    logic       s2_last;
    logic       m2_valid;
    logic       m2_ready;
    logic [7:0] m2_min;
    logic [7:0] m2_max;
    logic [1:0] m2_min_idx;
    logic [1:0] m2_max_idx;
    logic [1:0] m2_count;

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    exp_t q2[$];
    logic [7:0] vec [8];

    always #5 clk = ~clk;

    minmax_scan_ctrl #(.W(8), .CW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_signed (cfg_signed),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_min      (m_min),
        .m_max      (m_max),
        .m_min_idx  (m_min_idx),
        .m_max_idx  (m_max_idx),
        .m_count    (m_count)
    );

    minmax_scan_ctrl #(.W(8), .CW(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_signed (1'b0),
        .s_valid    (s2_valid),
        .s_ready    (s2_ready),
        .s_data     (s2_data),
        .s_last     (s2_last),
        .m_valid    (m2_valid),
        .m_ready    (m2_ready),
        .m_min      (m2_min),
        .m_max      (m2_max),
        .m_min_idx  (m2_min_idx),
        .m_max_idx  (m2_max_idx),
        .m_count    (m2_count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && m_valid && m_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("min", 32'(m_min), 32'(e.mn));
                chk("max", 32'(m_max), 32'(e.mx));
                chk("min_idx", 32'(m_min_idx), 32'(e.mni));
                chk("max_idx", 32'(m_max_idx), 32'(e.mxi));
                chk("count", 32'(m_count), 32'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst_n && m2_valid && m2_ready) begin
            if (q2.size() == 0) begin
                chk("unexpected_result2", 32'(q2.size()), 32'd1);
            end else begin
                e = q2.pop_front();
                chk("cw2_min", 32'(m2_min), 32'(e.mn));
                chk("cw2_max", 32'(m2_max), 32'(e.mx));
                chk("cw2_min_idx", 32'(m2_min_idx), 32'(e.mni));
                chk("cw2_max_idx", 32'(m2_max_idx), 32'(e.mxi));
                chk("cw2_count", 32'(m2_count), 32'(e.cnt));
            end
        end
    end

    // Returns at posedge+1 after the sample handshake.
    task automatic send(input logic [7:0] d, input logic l);
        int t;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("s_handshake_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic frame(input int n, input logic sg, input logic flip,
                         input int hold, input exp_t e);
        int lat;
        q.push_back(e);
        cfg_signed = sg;
        for (int i = 0; i < n; i++) begin
            send(vec[i], i == n - 1);
            if (flip && i == 0) cfg_signed = ~sg;
        end
        @(negedge clk);
        lat = 1;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("result_latency", 32'(lat), (n == 1) ? 32'd1 : 32'd3);
        chk("s_ready_in_done", 32'(s_ready), 32'd0);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_s_ready", 32'(s_ready), 32'd0);
                chk("hold_min", 32'(m_min), 32'(e.mn));
                chk("hold_max", 32'(m_max), 32'(e.mx));
                @(negedge clk);
            end
            @(posedge clk);
            #1 m_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("s_ready_after_hs", 32'(s_ready), 32'd1);
        chk("m_valid_after_hs", 32'(m_valid), 32'd0);
        cfg_signed = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n      = 1'b0;
        cfg_signed = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        m_ready    = 1'b1;
        s2_valid   = 1'b0;
        s2_data    = '0;
        s2_last    = 1'b0;
        m2_ready   = 1'b1;
        #2;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_count", 32'(m_count), 32'd0);
        chk("rst_min", 32'(m_min), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready_pre_edge", 32'(s_ready), 32'd0);
        @(negedge clk);
        chk("rel_s_ready", 32'(s_ready), 32'd1);

        vec = '{8'h05, 8'h03, 8'h09, 8'h03, 8'h09, 8'h00, 8'h00, 8'h00};
        frame(5, 1'b0, 1'b0, 0, '{8'h03, 8'h09, 8'd1, 8'd2, 8'd5});

        vec = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(3, 1'b1, 1'b1, 0, '{8'h80, 8'h7F, 8'd1, 8'd0, 8'd3});
        frame(3, 1'b0, 1'b0, 0, '{8'h00, 8'h80, 8'd2, 8'd1, 8'd3});

        vec = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(1, 1'b0, 1'b0, 0, '{8'h42, 8'h42, 8'd0, 8'd0, 8'd1});

        vec = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m_ready = 1'b0;
        frame(2, 1'b0, 1'b0, 10, '{8'h01, 8'h02, 8'd0, 8'd1, 8'd2});

        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_count", 32'(m_count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_no_valid", 32'(m_valid), 32'd0);
        end
        vec = '{8'h07, 8'h02, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(3, 1'b0, 1'b0, 0, '{8'h02, 8'h08, 8'd1, 8'd2, 8'd3});

        vec = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 8'h00, 8'h00, 8'h00};
        q2.push_back('{8'd5, 8'd40, 8'd3, 8'd3, 8'd3});
        for (int i = 0; i < 5; i++) begin
            s2_data  = vec[i];
            s2_last  = (i == 4);
            s2_valid = 1'b1;
            t = 0;
            while (!s2_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk("s2_handshake_timeout", 32'(t), 32'd0);
            @(posedge clk);
            #1;
            s2_valid = 1'b0;
            s2_last  = 1'b0;
        end

        repeat (8) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        chk("scoreboard2_drained", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
